// File: rtl/decision_unit_ctrl_if.sv
// ---------------------------------------------------------------------------
// decision_unit_ctrl_if
//
// Purpose: error-location bit stream from the decision-unit sequencer to the
//          bit-flip corrector, carried under a valid/ready handshake.
//
// Signals:
//   out_valid    errLoc beat valid           (master -> slave)
//   out_errLoc   error-location bit          (master -> slave)
//   out_bit_idx  index of the current beat   (master -> slave)
//   out_last     current beat is the last    (master -> slave)
//   in_ready     downstream ready            (slave  -> master)
//
// Modports: master (sequencer side), slave (corrector side).
// ---------------------------------------------------------------------------
interface decision_unit_ctrl_if #(
    parameter int CNT_LEN = 10
);
    logic               out_valid;
    logic               out_errLoc;
    logic [CNT_LEN-1:0] out_bit_idx;
    logic               out_last;
    logic               in_ready;

    modport master (
        output out_valid,
        output out_errLoc,
        output out_bit_idx,
        output out_last,
        input  in_ready
    );

    modport slave (
        input  out_valid,
        input  out_errLoc,
        input  out_bit_idx,
        input  out_last,
        output in_ready
    );
endinterface

// File: rtl/decision_unit_ctrl.sv
// ---------------------------------------------------------------------------
// decision_unit_ctrl
//
// Purpose: per-codeword sequencer for the soft-decision decision unit. On a
//          start pulse it initialises the unit, waits out the equal-FIFO fill
//          latency, then streams CODE_LEN error-location bits downstream.
//
// Ports:
//   clk                 clock, rising edge
//   in_ctr_rstn         asynchronous active-low reset
//   in_ctr_Srst         synchronous abort, active-high, highest priority
//   in_start            one-cycle pulse: new codeword ready at the unit
//   in_sel_none         no selectable test pattern (sampled in INIT)
//   in_du_sel_tp_equal  decision unit out_sel_tp_equal
//   stream              errLoc stream (master modport of decision_unit_ctrl_if)
//   out_du_Srst/en/init/getDeg/done   decision unit control inputs
//   out_busy            high outside IDLE
//   out_uncorr          codeword uncorrectable, held until next INIT
//   out_frame_done      one-cycle pulse at end of codeword
//   out_start_drop      one-cycle pulse: start arrived while busy
//   out_err_total       (optional) count of accepted beats with errLoc=1
//
// Optional feature: define DECISION_UNIT_CTRL_ERRCNT_EN to add out_err_total.
// ---------------------------------------------------------------------------
module decision_unit_ctrl #(
    parameter int CODE_LEN = 1023,
    parameter int FIFO_LAT = 1023,
    parameter int CNT_LEN  = 10
) (
    input  logic                 clk,
    input  logic                 in_ctr_rstn,
    input  logic                 in_ctr_Srst,
    input  logic                 in_start,
    input  logic                 in_sel_none,
    input  logic                 in_du_sel_tp_equal,
    decision_unit_ctrl_if.master stream,
    output logic                 out_du_Srst,
    output logic                 out_du_en,
    output logic                 out_du_init,
    output logic                 out_du_getDeg,
    output logic                 out_du_done,
    output logic                 out_busy,
    output logic                 out_uncorr,
    output logic                 out_frame_done,
    output logic                 out_start_drop
`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
    ,
    output logic [CNT_LEN-1:0]   out_err_total
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        FILL,
        STREAM,
        FIN
    } state_t;

    localparam logic [CNT_LEN-1:0] FILL_END = CNT_LEN'(FIFO_LAT - 1);
    localparam logic [CNT_LEN-1:0] LAST_IDX = CNT_LEN'(CODE_LEN - 1);
    localparam logic [CNT_LEN-1:0] ONE      = CNT_LEN'(1);

    state_t             state;
    state_t             next_state;
    logic [CNT_LEN-1:0] cnt;
    logic               uncorr_q;
    logic               drop_q;

    // One counter serves both the fill latency and the beat index; it is
    // reset to zero when leaving FILL and when the last beat is accepted.
    always_ff @(posedge clk or negedge in_ctr_rstn) begin
        if (!in_ctr_rstn) begin
            state    <= IDLE;
            cnt      <= '0;
            uncorr_q <= 1'b0;
            drop_q   <= 1'b0;
        end else if (in_ctr_Srst) begin
            state    <= IDLE;
            cnt      <= '0;
            uncorr_q <= 1'b0;
            drop_q   <= 1'b0;
        end else begin
            state  <= next_state;
            drop_q <= in_start && (state != IDLE);
            case (state)
                INIT: begin
                    uncorr_q <= in_sel_none;
                    cnt      <= '0;
                end
                FILL: cnt <= (cnt == FILL_END) ? '0 : cnt + ONE;
                STREAM: begin
                    if (stream.in_ready) begin
                        cnt <= (cnt == LAST_IDX) ? '0 : cnt + ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next state and per-state outputs. Srst overrides everything in the
    // same cycle: only out_du_Srst may be high while the abort is asserted.
    always_comb begin
        next_state        = state;
        out_du_Srst       = 1'b0;
        out_du_en         = 1'b0;
        out_du_init       = 1'b0;
        out_du_getDeg     = 1'b0;
        out_du_done       = 1'b0;
        out_busy          = (state != IDLE);
        out_frame_done    = 1'b0;
        stream.out_valid  = 1'b0;
        stream.out_bit_idx = '0;
        stream.out_last   = 1'b0;

        case (state)
            IDLE: begin
                if (in_start) next_state = INIT;
            end
            INIT: begin
                out_du_en     = 1'b1;
                out_du_init   = 1'b1;
                out_du_getDeg = 1'b1;
                next_state    = FILL;
            end
            FILL: begin
                out_du_en = 1'b1;
                if (cnt == FILL_END) next_state = STREAM;
            end
            STREAM: begin
                // Enable follows ready so a stall freezes the unit's datapath.
                stream.out_valid   = 1'b1;
                stream.out_bit_idx = cnt;
                stream.out_last    = (cnt == LAST_IDX);
                out_du_en          = stream.in_ready;
                if (stream.in_ready && (cnt == LAST_IDX)) begin
                    out_du_done = 1'b1;
                    next_state  = FIN;
                end
            end
            FIN: begin
                out_frame_done = 1'b1;
                next_state     = IDLE;
            end
            default: next_state = IDLE;
        endcase

        if (in_ctr_Srst) begin
            next_state         = IDLE;
            out_du_en          = 1'b0;
            out_du_init        = 1'b0;
            out_du_getDeg      = 1'b0;
            out_du_done        = 1'b0;
            out_busy           = 1'b0;
            out_frame_done     = 1'b0;
            stream.out_valid   = 1'b0;
            stream.out_bit_idx = '0;
            stream.out_last    = 1'b0;
            out_du_Srst        = in_ctr_rstn;
        end
    end

    assign stream.out_errLoc = stream.out_valid && in_du_sel_tp_equal;
    assign out_uncorr        = uncorr_q && !in_ctr_Srst;
    assign out_start_drop    = drop_q && !in_ctr_Srst;

`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
    logic [CNT_LEN-1:0] err_q;

    // Saturating count of accepted beats that flag an error location.
    always_ff @(posedge clk or negedge in_ctr_rstn) begin
        if (!in_ctr_rstn) begin
            err_q <= '0;
        end else if (in_ctr_Srst || (state == INIT)) begin
            err_q <= '0;
        end else if ((state == STREAM) && stream.in_ready && in_du_sel_tp_equal
                     && (err_q != '1)) begin
            err_q <= err_q + ONE;
        end
    end

    assign out_err_total = in_ctr_Srst ? '0 : err_q;
`endif

endmodule

// File: tb/tb_decision_unit_ctrl.sv
// ---------------------------------------------------------------------------
// tb_decision_unit_ctrl
//
// Purpose: self-checking bench for decision_unit_ctrl with CODE_LEN=8,
//          FIFO_LAT=3, CNT_LEN=4. A frame-level model predicts every output
//          each cycle; directed frames pin the timing with literal values.
//          Define DECISION_UNIT_CTRL_ERRCNT_EN to also cover out_err_total.
// ---------------------------------------------------------------------------
module tb_decision_unit_ctrl;

    localparam int CODE_LEN = 8;
    localparam int FIFO_LAT = 3;
    localparam int CNT_LEN  = 4;

    logic       clk = 1'b0;
    logic       rstn;
    logic       srst;
    logic       start;
    logic       sel_none;
    logic [7:0] pat;
    logic       du_eq;

    logic du_srst, du_en, du_init, du_get, du_done;
    logic busy, uncorr, frame_done, start_drop;
`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
    logic [CNT_LEN-1:0] err_total;
`endif

    decision_unit_ctrl_if #(.CNT_LEN(CNT_LEN)) bus ();

    decision_unit_ctrl #(
        .CODE_LEN(CODE_LEN),
        .FIFO_LAT(FIFO_LAT),
        .CNT_LEN (CNT_LEN)
    ) dut (
        .clk               (clk),
        .in_ctr_rstn       (rstn),
        .in_ctr_Srst       (srst),
        .in_start          (start),
        .in_sel_none       (sel_none),
        .in_du_sel_tp_equal(du_eq),
        .stream            (bus),
        .out_du_Srst       (du_srst),
        .out_du_en         (du_en),
        .out_du_init       (du_init),
        .out_du_getDeg     (du_get),
        .out_du_done       (du_done),
        .out_busy          (busy),
        .out_uncorr        (uncorr),
        .out_frame_done    (frame_done),
        .out_start_drop    (start_drop)
`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
        ,
        .out_err_total     (err_total)
`endif
    );

    // The unit's equality flag follows the beat being presented.
    assign du_eq = pat[bus.out_bit_idx[2:0]];

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int assert_count = 0;
    int fail_count   = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    // Frame-level model: a frame is counted in cycles since the start was
    // taken (0 = init cycle, 1..FIFO_LAT = fill) and then in accepted beats.
    bit m_active = 0;
    bit m_fin    = 0;
    int m_t      = 0;
    int m_beats  = 0;
    bit m_unc    = 0;
    bit m_drop   = 0;
    int m_err    = 0;

    task automatic compareModel();
        logic e_srst, e_en, e_init, e_get, e_done, e_busy;
        logic e_valid, e_err, e_last, e_unc, e_fd, e_drop;
        int   e_idx, e_tot;
        bit   in_init, in_fill, in_str, in_fin;
        {e_srst, e_en, e_init, e_get, e_done, e_busy} = '0;
        {e_valid, e_err, e_last, e_unc, e_fd, e_drop} = '0;
        e_idx = 0;
        e_tot = 0;
        if (rstn) begin
            if (srst) begin
                e_srst = 1'b1;
            end else begin
                in_init = m_active && (m_t == 0);
                in_fill = m_active && (m_t >= 1) && (m_t <= FIFO_LAT);
                in_str  = m_active && (m_t > FIFO_LAT) && !m_fin;
                in_fin  = m_active && m_fin;
                e_busy  = m_active;
                e_init  = in_init;
                e_get   = in_init;
                e_en    = in_init || in_fill || (in_str && bus.in_ready);
                e_valid = in_str;
                e_idx   = in_str ? m_beats : 0;
                e_last  = in_str && (m_beats == CODE_LEN - 1);
                e_done  = e_last && bus.in_ready;
                e_err   = in_str && pat[m_beats & 7];
                e_fd    = in_fin;
                e_drop  = m_drop;
                e_unc   = m_unc;
                e_tot   = m_err;
            end
        end
        checkOutput("du_Srst",    32'(du_srst),         32'(e_srst));
        checkOutput("du_en",      32'(du_en),           32'(e_en));
        checkOutput("du_init",    32'(du_init),         32'(e_init));
        checkOutput("du_getDeg",  32'(du_get),          32'(e_get));
        checkOutput("du_done",    32'(du_done),         32'(e_done));
        checkOutput("busy",       32'(busy),            32'(e_busy));
        checkOutput("valid",      32'(bus.out_valid),   32'(e_valid));
        checkOutput("errLoc",     32'(bus.out_errLoc),  32'(e_err));
        checkOutput("bit_idx",    32'(bus.out_bit_idx), 32'(e_idx));
        checkOutput("last",       32'(bus.out_last),    32'(e_last));
        checkOutput("uncorr",     32'(uncorr),          32'(e_unc));
        checkOutput("frame_done", 32'(frame_done),      32'(e_fd));
        checkOutput("start_drop", 32'(start_drop),      32'(e_drop));
`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
        checkOutput("err_total",  32'(err_total),       32'(e_tot));
`else
        if (e_tot < 0) checkOutput("err_total_model", 32'(e_tot), 32'd0);
`endif
    endtask

    task automatic stepModel();
        if (!rstn) begin
            m_active = 0; m_fin = 0; m_t = 0; m_beats = 0;
            m_unc = 0; m_drop = 0; m_err = 0;
        end else if (srst) begin
            m_active = 0; m_fin = 0; m_unc = 0; m_drop = 0; m_err = 0;
        end else begin
            m_drop = start && m_active;
            if (!m_active) begin
                if (start) begin
                    m_active = 1; m_t = 0; m_beats = 0; m_fin = 0;
                end
            end else if (m_fin) begin
                m_active = 0;
            end else if (m_t == 0) begin
                m_unc = sel_none;
                m_err = 0;
                m_t   = 1;
            end else if (m_t <= FIFO_LAT) begin
                m_t++;
            end else if (bus.in_ready) begin
                if (pat[m_beats & 7] && (m_err < (1 << CNT_LEN) - 1)) m_err++;
                m_beats++;
                if (m_beats == CODE_LEN) m_fin = 1;
            end
        end
    endtask

    // Every falling edge: check all outputs against the model, then advance it.
    initial begin
        forever begin
            @(negedge clk);
            compareModel();
            stepModel();
        end
    end

    // Results of the most recent frame, as offsets from the start cycle.
    int r_first, r_done, r_fd_off, r_drops, r_fds, r_unc, r_tot;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one frame. Indices of -1 disable stall, busy start, abort or reset.
    task automatic applyStimulus(input int stall_idx, input int stall_len,
                                 input int drop_at, input int abort_idx,
                                 input int rst_idx, input logic sn,
                                 input logic [7:0] p);
        int  s;
        int  stall_cnt;
        bit  stall_done, aborted, rst_done;
        pat = p;
        sel_none = sn;
        r_first = -1; r_done = -1; r_fd_off = -1;
        r_drops = 0; r_fds = 0; r_unc = -1; r_tot = -1;
        stall_cnt = 0; stall_done = 0; aborted = 0; rst_done = 0;
        tick();
        start = 1'b1;
        s = cyc;
        for (int k = 0; k < 40; k++) begin
            if (k > 0) begin
                tick();
                start = (k == drop_at);
            end
            srst = 1'b0;
            rstn = 1'b1;
            bus.in_ready = 1'b1;
            if (bus.out_valid && int'(bus.out_bit_idx) == stall_idx && !stall_done) begin
                bus.in_ready = 1'b0;
                stall_cnt++;
                if (stall_cnt == stall_len) stall_done = 1;
            end
            if (bus.out_valid && int'(bus.out_bit_idx) == abort_idx && !aborted) begin
                srst = 1'b1;
                aborted = 1;
            end
            if (bus.out_valid && int'(bus.out_bit_idx) == rst_idx && !rst_done) begin
                rstn = 1'b0;
                rst_done = 1;
                #1;
                checkOutput("arst_busy",    32'(busy),            32'd0);
                checkOutput("arst_valid",   32'(bus.out_valid),   32'd0);
                checkOutput("arst_du_en",   32'(du_en),           32'd0);
                checkOutput("arst_uncorr",  32'(uncorr),          32'd0);
                checkOutput("arst_bit_idx", 32'(bus.out_bit_idx), 32'd0);
            end
            @(negedge clk);
            if (bus.out_valid && r_first < 0) r_first = cyc - s;
            if (du_done) r_done = cyc - s;
            if (start_drop) r_drops++;
            if (frame_done) begin
                r_fds++;
                r_fd_off = cyc - s;
                r_unc = int'(uncorr);
`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
                r_tot = int'(err_total);
`endif
                break;
            end
        end
        tick();
        start = 1'b0;
        srst = 1'b0;
        rstn = 1'b1;
        bus.in_ready = 1'b1;
    endtask

    initial begin
        rstn = 1'b1; srst = 1'b0; start = 1'b0; sel_none = 1'b0;
        pat = 8'h00; bus.in_ready = 1'b1;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_busy",   32'(busy),            32'd0);
        checkOutput("reset_valid",  32'(bus.out_valid),   32'd0);
        checkOutput("reset_uncorr", 32'(uncorr),          32'd0);
        rstn = 1'b1;

        $display("[TB] basic frame");
        applyStimulus(-1, 0, -1, -1, -1, 1'b0, 8'hA5);
        checkOutput("basic_first_valid", 32'(r_first),  32'd5);
        checkOutput("basic_du_done",     32'(r_done),   32'd12);
        checkOutput("basic_frame_done",  32'(r_fd_off), 32'd13);
        checkOutput("basic_drops",       32'(r_drops),  32'd0);

        $display("[TB] backpressure at idx 4");
        applyStimulus(4, 3, -1, -1, -1, 1'b0, 8'h3C);
        checkOutput("bp_first_valid", 32'(r_first),  32'd5);
        checkOutput("bp_du_done",     32'(r_done),   32'd15);
        checkOutput("bp_frame_done",  32'(r_fd_off), 32'd16);

        $display("[TB] start while busy");
        applyStimulus(-1, 0, 2, -1, -1, 1'b0, 8'h5A);
        checkOutput("drop_count",      32'(r_drops),  32'd1);
        checkOutput("drop_frame_done", 32'(r_fd_off), 32'd13);

        $display("[TB] abort at idx 5");
        applyStimulus(-1, 0, -1, 5, -1, 1'b0, 8'hFF);
        checkOutput("abort_frame_dones", 32'(r_fds), 32'd0);
        applyStimulus(-1, 0, -1, -1, -1, 1'b0, 8'h01);
        checkOutput("post_abort_frame_done", 32'(r_fd_off), 32'd13);

        $display("[TB] uncorrectable frame");
        applyStimulus(-1, 0, -1, -1, -1, 1'b1, 8'h8D);
        checkOutput("uncorr_at_fin", 32'(r_unc), 32'd1);
`ifdef DECISION_UNIT_CTRL_ERRCNT_EN
        checkOutput("err_total_at_fin", 32'(r_tot), 32'd4);
`endif

        $display("[TB] async reset mid stream");
        applyStimulus(-1, 0, -1, -1, 3, 1'b1, 8'hF0);
        checkOutput("arst_frame_dones", 32'(r_fds), 32'd0);
        applyStimulus(-1, 0, -1, -1, -1, 1'b0, 8'h81);
        checkOutput("post_arst_frame_done", 32'(r_fd_off), 32'd13);
        checkOutput("post_arst_uncorr",     32'(r_unc),    32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assert_count, fail_count);
        $finish;
    end

endmodule
